branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning in-flight prediction FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: pred_valid  in  1  fetch issued a branch prediction this cycle.
REQ-005 SHALL have ports: pred_pc  in  32  branch instruction address.
REQ-006 SHALL have ports: pred_imme  in  32  sign-extended branch offset.
REQ-007 SHALL have ports: pred_take  in  1  predicted direction (1 = taken).
REQ-008 SHALL have ports: ex_valid  in  1  oldest branch has operands in EX this cycle.
REQ-009 SHALL have ports: ex_funct3  in  3  branch condition code.
REQ-010 SHALL have ports: ex_rs1, ex_rs2  in  32 each  compare operands.
REQ-011 SHALL have ports: stall  in  1  load-use stall; freezes the block.
REQ-012 SHALL have ports: flush  out  1  misprediction pulse.
REQ-013 SHALL have ports: redirect_pc  out  32  correct next PC, valid with flush.
REQ-014 SHALL have ports: upd_valid  out  1  predictor-table update pulse.
REQ-015 SHALL have ports: upd_index  out  10, upd_tag  out  22, upd_taken  out  1  = pc[9:0], pc[31:10], actual outcome.
REQ-016 SHALL have ports: full, empty  out  1 each  FIFO status, combinational from occupancy.
REQ-017 SHALL have ports: overflow_err, underflow_err  out  1 each  sticky error flags.
REQ-018 SHALL have ports: branch_cnt, mispredict_cnt  out  16 each  statistics.

Function
REQ-019 SHALL push {pred_pc, pred_imme, pred_take} when pred_valid && !stall && (!full || pop this cycle).
REQ-020 SHALL set overflow_err and drop the entry on pred_valid && !stall && full && no pop.
REQ-021 SHALL pop the oldest entry when ex_valid && !stall && !empty; a same-cycle push is not visible to the pop.
REQ-022 SHALL set underflow_err on ex_valid && !stall && empty; no output pulse, counters unchanged.
REQ-023 SHALL evaluate taken: 000 rs1==rs2; 001 !=; 100 signed <; 101 signed >=; 110 unsigned <; 111 unsigned >=; 010/011 not taken.
REQ-024 SHALL register results one cycle after the pop: upd_valid=1, upd_index/tag from popped pc, upd_taken=taken.
REQ-025 SHALL in that same cycle drive flush = (taken != pred_take) and redirect_pc = taken ? pc+imme : pc+4 (mod 2^32).
REQ-026 SHALL hold flush, upd_valid high for exactly one cycle per pop; redirect_pc/upd_* hold last value otherwise.
REQ-027 SHALL, in a cycle with flush=1, empty the FIFO at the clock edge ending that cycle; pushes and pops in that cycle are discarded and raise no error flags.
REQ-028 SHALL, with stall=1, perform no push, pop, or counter update, and drive flush=upd_valid=0 next cycle; a pulse already registered is not suppressed.
REQ-029 SHALL increment branch_cnt per pop and mispredict_cnt per flush, each saturating at 0xFFFF.
REQ-030 SHALL keep full = (occupancy==DEPTH), empty = (occupancy==0); pointers wrap modulo DEPTH.

Reset
REQ-031 SHALL on reset assertion immediately clear FIFO pointers/occupancy, flush, upd_valid, upd_taken, redirect_pc, upd_index, upd_tag, error flags, and counters to 0; empty=1, full=0.
REQ-032 SHALL discard in-flight entries on reset mid-operation; no pulse follows deassertion.

Verification
REQ-033 SHALL cover: push pc=0x100, imme=0x20, take=1; pop funct3=000, rs1=rs2=5 -> next cycle upd_valid=1, upd_index=0x100, upd_tag=0, upd_taken=1, flush=0.
REQ-034 SHALL cover: push pc=0x400, imme=0xFFFFFFF0, take=1; pop funct3=100, rs1=3, rs2=1 -> flush=1, redirect_pc=0x404, mispredict_cnt=1, FIFO empty next cycle.
REQ-035 SHALL cover: 5 pushes with DEPTH=4, no pops -> full=1 after 4th, overflow_err=1 after 5th, 5th entry absent on later pops.
REQ-036 SHALL cover: ex_valid on empty FIFO -> underflow_err=1, upd_valid=0, branch_cnt unchanged.
REQ-037 SHALL cover: stall=1 with pred_valid=ex_valid=1 for 3 cycles -> occupancy unchanged, no pulses; on release pop/push proceed.
REQ-038 SHALL cover: funct3=110, rs1=0xFFFFFFFF, rs2=1, pred_take=1 -> taken=0, flush=1, redirect_pc=pc+4; reset asserted with 2 entries -> empty=1 immediately.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver: queues fetch-time branch predictions and resolves them in EX, raising flush/redirect and predictor updates.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_imme,
  input  logic        pred_take,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic        stall,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [9:0]  upd_index,
  output logic [21:0] upd_tag,
  output logic        upd_taken,
  output logic        full,
  output logic        empty,
  output logic        overflow_err,
  output logic        underflow_err,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] imme_mem [DEPTH];
  logic [DEPTH-1:0] take_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic act, push, pop, taken, mis;
  logic [31:0] head_pc, head_imme;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // a flush cycle discards everything the pipeline offers, so it gates both ends
  assign act = !stall && !flush;
  assign pop = act && ex_valid && !empty;
  assign push = act && pred_valid && (!full || pop);
  assign head_pc = pc_mem[rd_ptr];
  assign head_imme = imme_mem[rd_ptr];
  assign mis = taken != take_mem[rd_ptr];
  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      3'b000: taken = ex_rs1 == ex_rs2;
      3'b001: taken = ex_rs1 != ex_rs2;
      3'b100: taken = $signed(ex_rs1) < $signed(ex_rs2);
      3'b101: taken = $signed(ex_rs1) >= $signed(ex_rs2);
      3'b110: taken = ex_rs1 < ex_rs2;
      3'b111: taken = ex_rs1 >= ex_rs2;
      default: taken = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pred_pc;
      imme_mem[wr_ptr] <= pred_imme;
      take_mem[wr_ptr] <= pred_take;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      flush <= 1'b0;
      upd_valid <= 1'b0;
      upd_taken <= 1'b0;
      redirect_pc <= '0;
      upd_index <= '0;
      upd_tag <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      upd_valid <= pop;
      flush <= pop && mis;
      if (pop) begin
        upd_index <= head_pc[9:0];
        upd_tag <= head_pc[31:10];
        upd_taken <= taken;
        redirect_pc <= taken ? head_pc + head_imme : head_pc + 32'd4;
        if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
        if (mis && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
      if (act && pred_valid && full && !pop) overflow_err <= 1'b1;
      if (act && ex_valid && empty) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic pred_valid = 0, pred_take = 0, ex_valid = 0, stall = 0;
  logic [31:0] pred_pc = 0, pred_imme = 0, ex_rs1 = 0, ex_rs2 = 0;
  logic [2:0] ex_funct3 = 0;
  logic flush, upd_valid, upd_taken, full, empty, overflow_err, underflow_err;
  logic [31:0] redirect_pc;
  logic [9:0] upd_index;
  logic [21:0] upd_tag;
  logic [15:0] branch_cnt, mispredict_cnt;
  int n_cmp = 0, n_fail = 0;
  typedef struct { logic [31:0] pc; logic [31:0] imme; logic take; } ent_t;
  ent_t q[$];
  logic m_flush, m_uv, m_taken, m_ovf, m_unf;
  logic [31:0] m_redir;
  logic [9:0] m_idx;
  logic [21:0] m_tag;
  int m_bc, m_mc;
  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_imme(pred_imme),
    .pred_take(pred_take), .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_taken(upd_taken), .full(full), .empty(empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic ref_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint ua = longint'({32'd0, a}), ub = longint'({32'd0, b});
    case (f)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    q.delete();
    {m_flush, m_uv, m_taken, m_ovf, m_unf} = '0;
    m_redir = 0; m_idx = 0; m_tag = 0; m_bc = 0; m_mc = 0;
  endtask
  task automatic tick();
    int sz = q.size();
    bit pp, pu, t;
    ent_t e;
    if (m_flush) begin
      q.delete(); m_flush = 0; m_uv = 0;
    end else if (stall) begin
      m_flush = 0; m_uv = 0;
    end else begin
      pp = ex_valid && sz > 0;
      pu = pred_valid && (sz < DEPTH || pp);
      if (pred_valid && sz == DEPTH && !pp) m_ovf = 1;
      if (ex_valid && sz == 0) m_unf = 1;
      m_uv = pp; m_flush = 0;
      if (pp) begin
        e = q.pop_front();
        t = ref_taken(ex_funct3, ex_rs1, ex_rs2);
        m_taken = t; m_idx = e.pc[9:0]; m_tag = e.pc[31:10];
        m_redir = t ? e.pc + e.imme : e.pc + 32'd4;
        m_flush = t != e.take;
        if (m_bc < 65535) m_bc++;
        if (m_flush && m_mc < 65535) m_mc++;
      end
      if (pu) q.push_back('{pred_pc, pred_imme, pred_take});
    end
    @(posedge clk); #1;
  endtask
  task automatic idle();
    pred_valid = 0; ex_valid = 0; stall = 0;
  endtask
  task automatic push1(logic [31:0] pc, logic [31:0] im, logic tk);
    pred_valid = 1; pred_pc = pc; pred_imme = im; pred_take = tk; ex_valid = 0;
    tick(); pred_valid = 0;
  endtask
  task automatic test_reset();
    #1;
    n_cmp++; if ({flush, upd_valid, upd_taken, full, overflow_err, underflow_err} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b want 000000", {flush, upd_valid, upd_taken, full, overflow_err, underflow_err}); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if ({redirect_pc, upd_index, upd_tag, branch_cnt, mispredict_cnt} !== '0) begin n_fail++; $display("FAIL reset_regs got %h want 0", {redirect_pc, upd_index, upd_tag, branch_cnt, mispredict_cnt}); end
    model_reset();
    @(negedge clk); reset = 0;
    tick();
  endtask
  task automatic test_basic();
    push1(32'h100, 32'h20, 1'b1);
    ex_valid = 1; ex_funct3 = 3'b000; ex_rs1 = 5; ex_rs2 = 5;
    tick(); ex_valid = 0;
    n_cmp++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_upd_valid got %b want 1", upd_valid); end
    n_cmp++; if (upd_index !== 10'h100 || upd_tag !== 22'd0) begin n_fail++; $display("FAIL basic_index_tag got %h/%h want 100/0", upd_index, upd_tag); end
    n_cmp++; if (upd_taken !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL basic_taken_flush got %b%b want 10", upd_taken, flush); end
    tick();
    n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %b want 0", upd_valid); end
  endtask
  task automatic test_mispredict();
    push1(32'h400, 32'hFFFF_FFF0, 1'b1);
    push1(32'h800, 32'h8, 1'b0);
    ex_valid = 1; ex_funct3 = 3'b100; ex_rs1 = 3; ex_rs2 = 1;
    tick();
    n_cmp++; if (flush !== 1'b1 || redirect_pc !== 32'h404) begin n_fail++; $display("FAIL misp_flush_redirect got %b/%h want 1/00000404", flush, redirect_pc); end
    n_cmp++; if (mispredict_cnt !== 16'd1) begin n_fail++; $display("FAIL misp_cnt got %0d want 1", mispredict_cnt); end
    pred_valid = 1; pred_pc = 32'h900;
    tick(); idle();
    n_cmp++; if (empty !== 1'b1 || flush !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL misp_drain got e%b f%b u%b want e1 f0 u0", empty, flush, upd_valid); end
    n_cmp++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL misp_no_err got %b%b want 00", overflow_err, underflow_err); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      push1(32'h2004 + 32'(i) * 8, 32'h40, 1'b0);
      if (i == 3) begin
        n_cmp++; if (full !== 1'b1 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_full got f%b o%b want f1 o0", full, overflow_err); end
      end
    end
    n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
    ex_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; tick(); ex_valid = 0;
      n_cmp++; if (upd_valid !== 1'b1 || upd_index !== 10'(32'h2004 + 32'(i) * 8)) begin n_fail++; $display("FAIL ovf_pop%0d got v%b %h want v1 %h", i, upd_valid, upd_index, 10'(32'h2004 + 32'(i) * 8)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_fifth_absent got empty=%b want 1", empty); end
  endtask
  task automatic test_underflow();
    logic [15:0] bc = branch_cnt;
    ex_valid = 1; tick(); ex_valid = 0;
    n_cmp++; if (underflow_err !== 1'b1 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL unf_flag got u%b v%b want u1 v0", underflow_err, upd_valid); end
    n_cmp++; if (branch_cnt !== bc) begin n_fail++; $display("FAIL unf_cnt got %0d want %0d", branch_cnt, bc); end
  endtask
  task automatic test_stall();
    push1(32'h5000, 32'h10, 1'b0);
    push1(32'h5100, 32'h10, 1'b0);
    stall = 1; pred_valid = 1; pred_pc = 32'h5200; ex_valid = 1; ex_funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (upd_valid !== 1'b0 || flush !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got v%b f%b e%b fu%b want 0000", i, upd_valid, flush, empty, full); end
    end
    stall = 0; tick(); idle();
    n_cmp++; if (upd_valid !== 1'b1 || upd_index !== 10'h000 || upd_tag !== 22'h14) begin n_fail++; $display("FAIL stall_release got v%b %h/%h want v1 000/14", upd_valid, upd_index, upd_tag); end
    for (int i = 0; i < 8 && q.size() > 0; i++) begin ex_valid = 1; tick(); end
    idle(); tick();
    n_cmp++; if (empty !== 1'b1 || branch_cnt !== 16'(m_bc)) begin n_fail++; $display("FAIL stall_drain got e%b bc%0d want e1 bc%0d", empty, branch_cnt, m_bc); end
  endtask
  task automatic test_unsigned_and_reset();
    push1(32'h3000, 32'h100, 1'b1);
    ex_valid = 1; ex_funct3 = 3'b110; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 1;
    tick(); ex_valid = 0;
    n_cmp++; if (upd_taken !== 1'b0 || flush !== 1'b1 || redirect_pc !== 32'h3004) begin n_fail++; $display("FAIL unsigned_lt got t%b f%b %h want t0 f1 00003004", upd_taken, flush, redirect_pc); end
    tick();
    push1(32'h6000, 32'h4, 1'b0);
    push1(32'h6004, 32'h4, 1'b0);
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset_occupied got %b want 0", empty); end
    @(negedge clk); reset = 1; #1;
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL async_reset got e%b f%b bc%0d mc%0d o%b want e1 f0 0 0 o0", empty, full, branch_cnt, mispredict_cnt, overflow_err); end
    model_reset();
    @(negedge clk); reset = 0; ex_valid = 1; ex_funct3 = 3'b010;
    tick(); idle();
    n_cmp++; if (upd_valid !== 1'b0 || flush !== 1'b0 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL post_reset got v%b f%b u%b want v0 f0 u1", upd_valid, flush, underflow_err); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pred_valid = $urandom_range(0, 1); ex_valid = $urandom_range(0, 1); stall = $urandom_range(0, 4) == 0;
      pred_pc = $urandom & 32'hFFFF_FFFC; pred_imme = $urandom_range(0, 1) ? 32'($signed(12'($urandom))) : $urandom;
      pred_take = $urandom_range(0, 1); ex_funct3 = 3'($urandom);
      ex_rs1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      ex_rs2 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      tick();
      n_cmp++; if (flush !== m_flush || upd_valid !== m_uv || upd_taken !== m_taken) begin n_fail++; $display("FAIL rand%0d_pulses got f%b v%b t%b want f%b v%b t%b", i, flush, upd_valid, upd_taken, m_flush, m_uv, m_taken); end
      n_cmp++; if (redirect_pc !== m_redir || upd_index !== m_idx || upd_tag !== m_tag) begin n_fail++; $display("FAIL rand%0d_data got %h %h %h want %h %h %h", i, redirect_pc, upd_index, upd_tag, m_redir, m_idx, m_tag); end
      n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rand%0d_occ got e%b f%b want size %0d", i, empty, full, q.size()); end
      n_cmp++; if (overflow_err !== m_ovf || underflow_err !== m_unf || branch_cnt !== 16'(m_bc) || mispredict_cnt !== 16'(m_mc)) begin n_fail++; $display("FAIL rand%0d_stats got o%b u%b %0d %0d want o%b u%b %0d %0d", i, overflow_err, underflow_err, branch_cnt, mispredict_cnt, m_ovf, m_unf, m_bc, m_mc); end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_mispredict();
    test_overflow();
    test_underflow();
    test_stall();
    test_unsigned_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
